rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_sequencer.sv | 141 ++++++++++++++
 tb/tb_rst_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer: merges a software reset pulse with a debounced external button, stretches
// rst_out, then waits a holdoff before signalling completion with a one-cycle done pulse.
module rst_sequencer #(
    parameter int STRETCH  = 16,
    parameter int HOLDOFF  = 4,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_req,
    input  logic       ext_req_n,
    output logic       rst_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] rst_count
);

    localparam int CNT_MAX = (STRETCH > HOLDOFF) ? STRETCH : HOLDOFF;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int DW      = $clog2(DEBOUNCE + 1);

    localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH - 1);
    localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF - 1);
    localparam logic [DW-1:0] DEB_LAST     = DW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_HOLDOFF,
        ST_DONE
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_fired_q, deb_fired_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_out_q, rst_out_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [7:0]    rst_count_q, rst_count_d;
    logic          ext_req;
    logic          req;
    logic [7:0]    count_inc;

    always_comb begin
        sync1_d     = ext_req_n;
        sync2_d     = sync1_q;
        deb_cnt_d   = deb_cnt_q;
        deb_fired_d = deb_fired_q;

        // One request per low period; the button must read high again before re-arming.
        ext_req = !sync2_q && !deb_fired_q && (deb_cnt_q == DEB_LAST);
        if (sync2_q) begin
            deb_cnt_d   = '0;
            deb_fired_d = 1'b0;
        end else if (ext_req) begin
            deb_fired_d = 1'b1;
        end else if (!deb_fired_q) begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end

        req       = sw_req | ext_req;
        count_inc = (rst_count_q == 8'hFF) ? rst_count_q : rst_count_q + 8'd1;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_count_d = rst_count_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    state_d     = ST_ASSERT;
                    cnt_d       = STRETCH_LOAD;
                    rst_count_d = count_inc;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (req) begin
                    cnt_d = STRETCH_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLDOFF_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (req) begin
                    state_d     = ST_ASSERT;
                    cnt_d       = STRETCH_LOAD;
                    rst_count_d = count_inc;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet track the state.
        rst_out_d = (state_d == ST_ASSERT);
        busy_d    = (state_d == ST_ASSERT) || (state_d == ST_HOLDOFF);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deb_cnt_q   <= '0;
            deb_fired_q <= 1'b0;
            state_q     <= ST_ASSERT;
            cnt_q       <= STRETCH_LOAD;
            rst_out_q   <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            rst_count_q <= 8'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_fired_q <= deb_fired_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_out_q   <= rst_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rst_count_q <= rst_count_d;
        end
    end

    assign rst_out   = rst_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rst_count = rst_count_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with STRETCH=16, HOLDOFF=4, DEBOUNCE=8; expected cycle
// positions and counts are hand-derived from the sequencing rules.
module tb_rst_sequencer;

    logic       clk;
    logic       rst;
    logic       sw_req;
    logic       ext_req_n;
    logic       rst_out;
    logic       busy;
    logic       done;
    logic [7:0] rst_count;

    int check_count;
    int error_count;
    int exp_count;
    int hi_cnt, busy_cnt, done_cnt, first_done, last_hi;
    int seen_hi;

    rst_sequencer #(
        .STRETCH (16),
        .HOLDOFF (4),
        .DEBOUNCE(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_req   (sw_req),
        .ext_req_n(ext_req_n),
        .rst_out  (rst_out),
        .busy     (busy),
        .done     (done),
        .rst_count(rst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed != expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic e);
        rst       = r;
        sw_req    = s;
        ext_req_n = e;
        @(posedge clk);
        #1;
    endtask

    // Sample n cycles starting from the current one; optionally pulse sw_req at index req_at.
    task automatic measure_sequence(input int n, input int req_at,
                                    output int hi, output int bz, output int dn,
                                    output int fd, output int lh);
        hi = 0; bz = 0; dn = 0; fd = -1; lh = -1;
        for (int k = 0; k < n; k++) begin
            if (rst_out === 1'b1) begin hi++; lh = k; end
            if (busy === 1'b1) bz++;
            if (done === 1'b1) begin
                dn++;
                if (fd < 0) fd = k;
            end
            applyStimulus(1'b0, (k == req_at), 1'b1);
        end
    endtask

    task automatic idle_cycles(input int n, input logic e);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, e);
    endtask

    initial begin
        check_count = 0;
        error_count = 0;

        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("reset_rst_out", rst_out, 1);
        checkOutput("reset_busy", busy, 1);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_count", rst_count, 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);

        measure_sequence(30, -1, hi_cnt, busy_cnt, done_cnt, first_done, last_hi);
        checkOutput("por_rst_out_cycles", hi_cnt, 16);
        checkOutput("por_busy_cycles", busy_cnt, 20);
        checkOutput("por_done_pulses", done_cnt, 1);
        checkOutput("por_done_pos", first_done, 20);
        checkOutput("por_count", rst_count, 0);

        applyStimulus(1'b0, 1'b1, 1'b1);
        measure_sequence(30, -1, hi_cnt, busy_cnt, done_cnt, first_done, last_hi);
        checkOutput("sw_rst_out_cycles", hi_cnt, 16);
        checkOutput("sw_last_hi", last_hi, 15);
        checkOutput("sw_busy_cycles", busy_cnt, 20);
        checkOutput("sw_done_pos", first_done, 20);
        checkOutput("sw_count", rst_count, 1);

        applyStimulus(1'b0, 1'b1, 1'b1);
        measure_sequence(35, 4, hi_cnt, busy_cnt, done_cnt, first_done, last_hi);
        checkOutput("retrig_rst_out_cycles", hi_cnt, 21);
        checkOutput("retrig_last_hi", last_hi, 20);
        checkOutput("retrig_done_pos", first_done, 25);
        checkOutput("retrig_count", rst_count, 2);

        applyStimulus(1'b0, 1'b1, 1'b1);
        measure_sequence(45, 17, hi_cnt, busy_cnt, done_cnt, first_done, last_hi);
        checkOutput("holdoff_rst_out_cycles", hi_cnt, 32);
        checkOutput("holdoff_last_hi", last_hi, 33);
        checkOutput("holdoff_busy_cycles", busy_cnt, 38);
        checkOutput("holdoff_done_pos", first_done, 38);
        checkOutput("holdoff_count", rst_count, 4);

        applyStimulus(1'b0, 1'b1, 1'b1);
        measure_sequence(45, 20, hi_cnt, busy_cnt, done_cnt, first_done, last_hi);
        checkOutput("done_req_rst_out_cycles", hi_cnt, 32);
        checkOutput("done_req_done_pulses", done_cnt, 2);
        checkOutput("done_req_first_done", first_done, 20);
        checkOutput("done_req_count", rst_count, 6);

        idle_cycles(7, 1'b0);
        idle_cycles(30, 1'b1);
        checkOutput("glitch_count", rst_count, 6);
        checkOutput("glitch_busy", busy, 0);

        idle_cycles(8, 1'b0);
        idle_cycles(30, 1'b1);
        checkOutput("deb8_count", rst_count, 7);

        seen_hi = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (rst_out === 1'b1) seen_hi++;
        end
        checkOutput("hold100_rst_out_cycles", seen_hi, 16);
        checkOutput("hold100_count", rst_count, 8);
        checkOutput("hold100_busy", busy, 0);
        idle_cycles(5, 1'b1);

        idle_cycles(9, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        idle_cycles(30, 1'b0);
        idle_cycles(5, 1'b1);
        checkOutput("simul_count", rst_count, 9);
        checkOutput("simul_busy", busy, 0);

        exp_count = 9;
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            idle_cycles(22, 1'b1);
            exp_count = (exp_count < 255) ? exp_count + 1 : 255;
            if (exp_count == 254 && rst_count != 8'd255) checkOutput("sat_254", rst_count, 254);
        end
        checkOutput("sat_count", rst_count, 255);
        checkOutput("sat_model", exp_count, 255);

        applyStimulus(1'b0, 1'b1, 1'b1);
        idle_cycles(17, 1'b1);
        checkOutput("mid_holdoff_rst_out", rst_out, 0);
        checkOutput("mid_holdoff_busy", busy, 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("rst_mid_count", rst_count, 0);
        checkOutput("rst_mid_rst_out", rst_out, 1);
        checkOutput("rst_mid_busy", busy, 1);
        checkOutput("rst_mid_done", done, 0);
        measure_sequence(30, -1, hi_cnt, busy_cnt, done_cnt, first_done, last_hi);
        checkOutput("rst_mid_rst_out_cycles", hi_cnt, 16);
        checkOutput("rst_mid_done_pos", first_done, 20);
        checkOutput("rst_mid_final_count", rst_count, 0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
